// File: rtl/nrzi_pkg.sv
// Shared constants, state encoding and decode helper for the NRZI receive front end.
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } nrzi_state_e;

  // Newest decoded bit sits in the MSB of the sync history.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam int         STUFF_LIMIT  = 6;
  localparam logic       IDLE_LEVEL   = 1'b1;

  // A line level equal to the previous one decodes as 1, a transition as 0.
  function automatic logic nrzi_decode(input logic line_level, input logic prev_level);
    return (line_level == prev_level);
  endfunction

endpackage

// File: rtl/nrzi_rx_if.sv
// Single-entry valid/ready word channel from the receiver to the packet logic.
interface nrzi_rx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/nrzi_bit_decoder.sv
// NRZI line decode plus bit-stuff filter; forwards only non-stuffed data bits.
module nrzi_bit_decoder
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  input  logic bit_en,
  input  logic frame_en,
  input  logic in_data,
  input  logic sync_hit,
  output logic dec_bit,
  output logic bit_strobe,
  output logic stuff_err
);

  localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

  logic       prev_line_reg;
  logic [2:0] ones_cnt_reg;
  logic       at_limit;
  logic       active;

  assign dec_bit    = nrzi_decode(line_in, prev_line_reg);
  assign at_limit   = (ones_cnt_reg == LIMIT);
  assign active     = bit_en & frame_en & in_data;
  // The bit following a run of STUFF_LIMIT ones is the stuffed bit and never reaches the deserializer.
  assign bit_strobe = active & ~at_limit;
  assign stuff_err  = active & at_limit & dec_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_line_reg <= IDLE_LEVEL;
    end else if (bit_en) begin
      prev_line_reg <= line_in;
    end
  end

  // The final sync bit is a 1, so the run count starts at 1 on entry to DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_reg <= 3'd0;
    end else if (!frame_en) begin
      ones_cnt_reg <= 3'd0;
    end else if (sync_hit) begin
      ones_cnt_reg <= 3'd1;
    end else if (!in_data) begin
      ones_cnt_reg <= 3'd0;
    end else if (bit_en) begin
      if (at_limit || !dec_bit) begin
        ones_cnt_reg <= 3'd0;
      end else begin
        ones_cnt_reg <= ones_cnt_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/nrzi_rx.sv
// NRZI serial receiver: sync hunt, destuffing, LSB-first deserializer and a
// single-entry valid/ready holding register.
module nrzi_rx
  import nrzi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_in,
  input  logic       bit_en,
  input  logic       frame_en,
  nrzi_rx_if.master  rx_bus,
  output logic       frame_active,
  output logic       sync_det,
  output logic       stuff_err,
  output logic       overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_HUNT = HUNT;
  localparam logic [1:0] S_DATA = DATA;
  localparam logic [1:0] S_ERR  = ERR;

  logic [1:0]        state_reg, state_next;
  logic [7:0]        hist_reg;
  logic [7:0]        hist_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              frame_active_reg;
  logic              sync_det_reg;
  logic              stuff_err_reg;
  logic              overrun_reg;

  logic dec_bit;
  logic bit_strobe;
  logic stuff_viol;
  logic sync_hit;
  logic word_done;
  logic load_ok;

  nrzi_bit_decoder u_decoder (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_in),
    .bit_en     (bit_en),
    .frame_en   (frame_en),
    .in_data    (state_reg == S_DATA),
    .sync_hit   (sync_hit),
    .dec_bit    (dec_bit),
    .bit_strobe (bit_strobe),
    .stuff_err  (stuff_viol)
  );

  assign hist_next = {dec_bit, hist_reg[7:1]};
  assign sync_hit  = frame_en & bit_en & (state_reg == S_HUNT) & (hist_next == SYNC_PATTERN);

  always_comb begin
    state_next = state_reg;
    if (!frame_en) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_HUNT;
        S_HUNT:  if (sync_hit) state_next = S_DATA;
        S_DATA:  if (stuff_viol) state_next = S_ERR;
        S_ERR:   state_next = S_ERR;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // History restarts at all-ones (idle line) so a lone 1 right after entering HUNT cannot match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= 8'hFF;
    end else if (!frame_en || state_reg != S_HUNT) begin
      hist_reg <= 8'hFF;
    end else if (bit_en) begin
      hist_reg <= hist_next;
    end
  end

  // Each incoming bit lands in the slot selected by the bit counter.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_word_bit
    assign word_next[gi] = (bit_cnt_reg == CNT_W'(gi)) ? dec_bit : word_reg[gi];
  end

  assign word_done = bit_strobe & (bit_cnt_reg == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= '0;
      word_reg    <= '0;
    end else if (!frame_en || state_reg != S_DATA || stuff_viol) begin
      bit_cnt_reg <= '0;
    end else if (bit_strobe) begin
      word_reg    <= word_next;
      bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
    end
  end

  assign load_ok = ~rx_valid_reg | rx_bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      overrun_reg <= word_done & ~load_ok;
      if (word_done && load_ok) begin
        rx_data_reg  <= word_next;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_bus.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active_reg <= 1'b0;
      sync_det_reg     <= 1'b0;
      stuff_err_reg    <= 1'b0;
    end else begin
      frame_active_reg <= (state_next == S_DATA);
      sync_det_reg     <= sync_hit;
      stuff_err_reg    <= stuff_viol;
    end
  end

  assign rx_bus.rx_data  = rx_data_reg;
  assign rx_bus.rx_valid = rx_valid_reg;
  assign frame_active    = frame_active_reg;
  assign sync_det        = sync_det_reg;
  assign stuff_err       = stuff_err_reg;
  assign overrun         = overrun_reg;

endmodule

// File: tb/tb_nrzi_rx.sv
// Directed bench for nrzi_rx: NRZI/stuffing encoder model feeding a word scoreboard.
module tb_nrzi_rx;

  logic clk;
  logic rst_n;
  logic line_in;
  logic bit_en;
  logic frame_en;
  logic frame_active;
  logic sync_det;
  logic stuff_err;
  logic overrun;

  nrzi_rx_if #(.DATA_W(8)) bus ();

  nrzi_rx #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_in      (line_in),
    .bit_en       (bit_en),
    .frame_en     (frame_en),
    .rx_bus       (bus),
    .frame_active (frame_active),
    .sync_det     (sync_det),
    .stuff_err    (stuff_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic       lvl;
  int         ones;
  logic       stuff_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=%h expected=none", bus.rx_data);
      end else begin
        check("sb_word", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && stuff_err) stuff_seen = 1'b1;
  end

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Decoded 1 keeps the line level, decoded 0 toggles it.
  task automatic send_raw(input logic d);
    if (!d) lvl = ~lvl;
    line_in = lvl;
    bit_en  = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic send_sync(input logic expect_hit);
    for (int i = 0; i < 7; i++) send_raw(1'b0);
    send_raw(1'b1);
    check("sync_det", 32'(sync_det), 32'(expect_hit));
    check("frame_active_sync", 32'(frame_active), 32'(expect_hit));
    ones = 1;
  endtask

  task automatic send_dbit(input logic d);
    if (ones == 6) begin
      send_raw(1'b0);
      ones = 0;
    end
    send_raw(d);
    ones = d ? ones + 1 : 0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic push, input logic raise_last);
    if (push) exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && raise_last) bus.rx_ready = 1'b1;
      send_dbit(w[i]);
    end
  endtask

  task automatic start_frame();
    frame_en = 1'b1;
    idle_cycle();
  endtask

  task automatic end_frame();
    frame_en = 1'b0;
    idle_cycle();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    lvl         = 1'b1;
    ones        = 0;
    stuff_seen  = 1'b0;
    rst_n       = 1'b0;
    line_in     = 1'b1;
    bit_en      = 1'b0;
    frame_en    = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_flags", 32'({sync_det, stuff_err, overrun}), 32'd0);
    rst_n = 1'b1;
    idle_cycle();

    // Basic word
    bus.rx_ready = 1'b1;
    start_frame();
    send_sync(1'b1);
    send_word(8'hA5, 1'b1, 1'b0);
    check("a5_valid", 32'(bus.rx_valid), 32'd1);
    check("a5_data", 32'(bus.rx_data), 32'hA5);
    check("sync_det_pulse", 32'(sync_det), 32'd0);
    idle_cycle();
    check("a5_valid_fall", 32'(bus.rx_valid), 32'd0);

    // Stuffing inside 0xFF, then 0x00
    stuff_seen = 1'b0;
    send_word(8'hFF, 1'b1, 1'b0);
    check("ff_data", 32'(bus.rx_data), 32'hFF);
    send_word(8'h00, 1'b1, 1'b0);
    check("00_data", 32'(bus.rx_data), 32'h00);
    idle_cycle();
    check("stuff_clean", 32'(stuff_seen), 32'd0);
    end_frame();

    // Stuff violation: six data 1s after the sync 1
    start_frame();
    send_sync(1'b1);
    for (int i = 0; i < 6; i++) send_raw(1'b1);
    check("stuff_err_pulse", 32'(stuff_err), 32'd1);
    check("err_not_active", 32'(frame_active), 32'd0);
    idle_cycle();
    check("stuff_err_fall", 32'(stuff_err), 32'd0);
    send_sync(1'b0);
    check("err_no_word", 32'(bus.rx_valid), 32'd0);
    end_frame();
    stuff_seen = 1'b0;

    // Backpressure and overrun
    bus.rx_ready = 1'b0;
    start_frame();
    send_sync(1'b1);
    send_word(8'h11, 1'b1, 1'b0);
    check("bp_valid", 32'(bus.rx_valid), 32'd1);
    check("bp_no_overrun", 32'(overrun), 32'd0);
    send_word(8'h22, 1'b0, 1'b0);
    check("overrun_pulse", 32'(overrun), 32'd1);
    check("bp_data_held", 32'(bus.rx_data), 32'h11);
    check("bp_valid_held", 32'(bus.rx_valid), 32'd1);
    idle_cycle();
    check("overrun_fall", 32'(overrun), 32'd0);
    bus.rx_ready = 1'b1;
    idle_cycle();
    check("accept_valid_fall", 32'(bus.rx_valid), 32'd0);
    bus.rx_ready = 1'b0;

    // Simultaneous accept and load
    send_word(8'h22, 1'b1, 1'b0);
    check("hold_22", 32'(bus.rx_data), 32'h22);
    send_word(8'h33, 1'b1, 1'b1);
    check("swap_valid", 32'(bus.rx_valid), 32'd1);
    check("swap_data", 32'(bus.rx_data), 32'h33);
    check("swap_no_overrun", 32'(overrun), 32'd0);
    idle_cycle();
    check("swap_drain", 32'(bus.rx_valid), 32'd0);
    end_frame();

    // Abort mid-word, re-sync, then 0x5A
    start_frame();
    send_sync(1'b1);
    send_dbit(1'b1);
    send_dbit(1'b0);
    send_dbit(1'b1);
    send_dbit(1'b1);
    frame_en = 1'b0;
    idle_cycle();
    check("abort_no_word", 32'(bus.rx_valid), 32'd0);
    check("abort_inactive", 32'(frame_active), 32'd0);
    start_frame();
    send_sync(1'b1);
    send_word(8'h5A, 1'b1, 1'b0);
    check("5a_data", 32'(bus.rx_data), 32'h5A);
    idle_cycle();

    // Asynchronous reset mid-word with a word held
    bus.rx_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    check("3c_held", 32'(bus.rx_data), 32'h3C);
    send_dbit(1'b0);
    send_dbit(1'b1);
    send_dbit(1'b0);
    check("pre_rst_active", 32'(frame_active), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("arst_rx_data", 32'(bus.rx_data), 32'd0);
    check("arst_frame_active", 32'(frame_active), 32'd0);
    check("arst_flags", 32'({sync_det, stuff_err, overrun}), 32'd0);
    frame_en = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
